// File: rtl/id_bitmap_decoder_pkg.sv
// id_bitmap_decoder helpers
// Width helper shared by the decoder and the tracker.
package id_bitmap_decoder_pkg;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/id_bitmap_decoder_onehot_decoder.sv
// onehot_decoder: binary ID to one-hot
// IDs outside 0..SEL_WIDTH-1 decode to all-zero.
module onehot_decoder
  import id_bitmap_decoder_pkg::*;
#(
  parameter  int SEL_WIDTH = 8,
  localparam int IDW = id_width(SEL_WIDTH)
) (
  input  logic [IDW-1:0]       id,
  output logic [SEL_WIDTH-1:0] onehot
);

  // A single-entry map ignores the ID bit entirely
  always_comb begin
    onehot = '0;
    for (int i = 0; i < SEL_WIDTH; i++) begin
      if (SEL_WIDTH == 1 || id == IDW'(i))
        onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/id_bitmap_decoder.sv
// id_bitmap_decoder: ID occupancy bitmap
// Tracks set/clear of IDs with count, strobe and sticky error.
module id_bitmap_decoder
  import id_bitmap_decoder_pkg::*;
#(
  parameter  int SEL_WIDTH    = 8,
  localparam int SEL_ID_WIDTH = id_width(SEL_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    set_vld_i,
  input  logic [SEL_ID_WIDTH-1:0] set_id_i,
  output logic                    set_rdy_o,
  input  logic                    clr_vld_i,
  input  logic [SEL_ID_WIDTH-1:0] clr_id_i,
  output logic [SEL_WIDTH-1:0]    bitmap_o,
  output logic                    dec_vld_o,
  output logic [SEL_WIDTH-1:0]    dec_onehot_o,
  output logic [SEL_ID_WIDTH:0]   used_cnt_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic                    err_o
);

  localparam int CW = SEL_ID_WIDTH + 1;

  logic [SEL_WIDTH-1:0] set_oh;
  logic [SEL_WIDTH-1:0] clr_oh;
  logic [SEL_WIDTH-1:0] set_mask;
  logic [SEL_WIDTH-1:0] clr_mask;
  logic [SEL_WIDTH-1:0] bitmap_nxt;
  logic                 clr_ok;
  logic                 same_id;
  logic                 err_set;
  logic                 err_clr;

  onehot_decoder #(
    .SEL_WIDTH(SEL_WIDTH)
  ) u_set_dec (
    .id     (set_id_i),
    .onehot (set_oh)
  );

  onehot_decoder #(
    .SEL_WIDTH(SEL_WIDTH)
  ) u_clr_dec (
    .id     (clr_id_i),
    .onehot (clr_oh)
  );

  // Zero one-hot means out of range, so no explicit compare
  assign set_rdy_o = set_vld_i
                   & (|set_oh)
                   & ~(|(set_oh & bitmap_o));

  assign clr_ok = clr_vld_i & (|(clr_oh & bitmap_o));

  // Set blocked only by its own same-cycle release is not an error
  assign same_id = clr_ok & (set_oh == clr_oh);
  assign err_set = set_vld_i & ~set_rdy_o & ~same_id;
  assign err_clr = clr_vld_i & ~clr_ok;

  assign set_mask   = set_rdy_o ? set_oh : '0;
  assign clr_mask   = clr_ok ? clr_oh : '0;
  assign bitmap_nxt = (bitmap_o | set_mask) & ~clr_mask;

  assign full_o  = (used_cnt_o == CW'(SEL_WIDTH));
  assign empty_o = (used_cnt_o == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitmap_o     <= '0;
      used_cnt_o   <= '0;
      dec_vld_o    <= 1'b0;
      dec_onehot_o <= '0;
      err_o        <= 1'b0;
    end else begin
      bitmap_o  <= bitmap_nxt;
      dec_vld_o <= set_rdy_o;
      if (set_rdy_o)
        dec_onehot_o <= set_oh;
      if (err_set | err_clr)
        err_o <= 1'b1;
      unique case ({set_rdy_o, clr_ok})
        2'b10:   used_cnt_o <= used_cnt_o + CW'(1);
        2'b01:   used_cnt_o <= used_cnt_o - CW'(1);
        default: used_cnt_o <= used_cnt_o;
      endcase
    end
  end

endmodule
